data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Data-memory responder for the load/store path of the RISC-V core. It serves the `mem_read`/`mem_write` requests raised by the control unit for lw/sw. It accepts one word access at a time and models a configurable access latency. It returns read data with a one-cycle `ready` pulse and reports misaligned word addresses instead of accessing memory.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- DEPTH_LOG2, 8, log2 of memory depth in words (256 words).
- LATENCY, 2, cycles from request acceptance to `ready`; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  read request (lw); held by the requester until `ready`.
- mem_write  input  1  write request (sw); held by the requester until `ready`.
- addr  input  32  byte address from the ALU.
- wdata  input  DATA_WIDTH  store data.
- rdata  output  DATA_WIDTH  load data; updated only by a completed aligned read.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high while an accepted access is in the WAIT state; used as the pipeline stall.
- misaligned  output  1  one-cycle flag, coincident with `ready`, for an access with addr[1:0] != 0.

Behaviour:
- Reset values:
  - state = IDLE; `rdata` = 0; `ready` = 0; `busy` = 0; `misaligned` = 0; latency counter = 0.
  - Memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `mem_read | mem_write` is sampled high at cycle N, the access is accepted.
  - On acceptance, capture op, addr and wdata into internal registers. Inputs are not used again for this access.
  - If both `mem_read` and `mem_write` are high, the write wins and the read is dropped.
  - Misaligned access (addr[1:0] != 0): go straight to RESP, giving `ready` at N+1 with `misaligned` = 1, regardless of LATENCY.
  - Aligned access with LATENCY = 1: go to RESP.
  - Aligned access with LATENCY > 1: go to WAIT and load the counter with LATENCY-1.
- WAIT:
  - `busy` = 1; decrement the counter each cycle.
  - When the counter reaches 1, go to RESP, so that `ready` is asserted in cycle N+LATENCY.
- RESP (exactly one cycle), then return to IDLE:
  - `ready` = 1, `busy` = 0.
  - Aligned read: `rdata` is registered so it is valid in the RESP cycle. Array index = captured addr[DEPTH_LOG2+1:2].
  - Aligned write: the array word is committed on the clock edge ending the RESP cycle. `rdata` is unchanged.
  - Misaligned access: no array access; `rdata` is unchanged; `misaligned` = 1.
- Request handling across cycles:
  - Requests present during WAIT or RESP are ignored and are not queued.
  - A request still high in the IDLE cycle after RESP is a new access. The requester must drop its request in the cycle after `ready`.
  - Throughput: one access per LATENCY+1 cycles.
- Address rules:
  - Address bits above DEPTH_LOG2+1 are ignored, so addresses wrap modulo 4*2^DEPTH_LOG2 bytes. No error is raised for wrapped addresses.
- Read-after-write: a read accepted after a write's RESP cycle returns the new data.
- `rdata` holds its last value between reads and is never X after reset.
- Reset mid-operation:
  - `rst` in any state returns to IDLE with all outputs at reset values.
  - A pending write is discarded, including when `rst` is asserted during the RESP cycle itself; the array word is unchanged.
- Assertions:
  - `ready` never high for two consecutive cycles.
  - `busy` and `ready` never high together.
  - `misaligned` implies `ready`.

Test Plan:
- Reset:
  - Stimulus: assert `rst` for 2 cycles, then hold requests at 0 for 5 cycles.
  - Required: `rdata` = 0, `ready` = 0, `busy` = 0, `misaligned` = 0 throughout.
- Write then read (LATENCY = 2):
  - Stimulus: sw, addr = 0x10, wdata = 0xDEADBEEF, accepted at cycle N; then lw, addr = 0x10.
  - Required for the write: `busy` = 1 at N+1, `ready` = 1 at N+2.
  - Required for the read: `ready` with `rdata` = 0xDEADBEEF two cycles after acceptance.
- Misaligned access:
  - Stimulus: write to 0x13 with wdata = 0x12345678 (LATENCY = 4).
  - Required: `ready` = 1 and `misaligned` = 1 at N+1, with no `busy` cycle.
  - Required: a subsequent lw from 0x10 still returns 0xDEADBEEF.
- Simultaneous read and write:
  - Stimulus: `mem_read` = `mem_write` = 1, addr = 0x20, wdata = 0xA5A5A5A5.
  - Required: `rdata` is unchanged at `ready`; a following lw from 0x20 returns 0xA5A5A5A5.
- Address wrap (DEPTH_LOG2 = 8):
  - Stimulus: sw to addr 0x400 with wdata = 0x0000CAFE.
  - Required: lw from 0x000 returns 0x0000CAFE.
- Reset mid-access (LATENCY = 3):
  - Stimulus: sw to 0x30 with wdata = 0x11111111 over an old value of 0x22222222; pulse `rst` at N+1 (WAIT), then repeat with `rst` pulsed in the RESP cycle.
  - Required: no `ready` pulse after reset; lw from 0x30 returns 0x22222222 in both cases.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory responder for the core's load/store path. It takes one word
//   access at a time, waits a configurable number of cycles, then gives a
//   one-cycle ready pulse. A misaligned word address is reported with the
//   misaligned flag and does not touch the memory array.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   mem_read    load request, held by the requester until ready
//   mem_write   store request, held by the requester until ready (wins over read)
//   addr        byte address; bits above DEPTH_LOG2+1 are ignored (address wraps)
//   wdata       store data
//   rdata       load data, changed only by a completed aligned read
//   ready       one-cycle completion pulse
//   busy        high in the WAIT state; used as the pipeline stall
//   misaligned  one-cycle flag with ready for addr[1:0] != 0
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  busy,
  output logic                  misaligned
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // WAIT is entered after the accepting edge, so it lasts LATENCY-1 cycles.
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  logic [1:0]            state;
  logic [3:0]            lat_cnt;
  logic                  op_write;
  logic                  op_misaligned;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic                  request;
  logic                  addr_misaligned;
  logic [DEPTH_LOG2-1:0] addr_idx;

  // Upper address bits are deliberately dropped so accesses wrap.
  logic                  unused_addr_bits;

  assign request          = mem_read | mem_write;
  assign addr_misaligned  = (addr[1:0] != 2'b00);
  assign addr_idx         = addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^addr[31:DEPTH_LOG2+2];

  assign ready      = (state == RESP);
  assign busy       = (state == WAIT);
  assign misaligned = (state == RESP) && op_misaligned;

  // Control FSM. The request is captured on acceptance; rdata is loaded on
  // the edge entering RESP so the load data is valid alongside ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= 4'd0;
      rdata         <= '0;
      op_write      <= 1'b0;
      op_misaligned <= 1'b0;
      word_idx      <= '0;
      wdata_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            op_write      <= mem_write;
            op_misaligned <= addr_misaligned;
            word_idx      <= addr_idx;
            wdata_q       <= wdata;
            if (addr_misaligned || LATENCY == 1) begin
              state <= RESP;
              if (!addr_misaligned && !mem_write) begin
                rdata <= mem[addr_idx];
              end
            end else begin
              state   <= WAIT;
              lat_cnt <= LAT_LOAD;
            end
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            state <= RESP;
            if (!op_write) begin
              rdata <= mem[word_idx];
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The store commits on the edge that ends RESP; a reset on that same edge
  // discards it.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && op_write && !op_misaligned) begin
      mem[word_idx] <= wdata_q;
    end
  end

  a_ready_single: assert property (@(posedge clk) disable iff (rst) ready |=> !ready);
  a_busy_ready:   assert property (@(posedge clk) disable iff (rst) !(busy && ready));
  a_mis_ready:    assert property (@(posedge clk) disable iff (rst) misaligned |-> ready);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder. Four instances share clk/rst and run with
// LATENCY = 2, 3, 4 and 1. Each access pushes its expected response into a
// scoreboard queue; the response is popped and compared when ready appears.
module tb_data_mem_responder;

  localparam int N_INST = 4;
  localparam int BUDGET = 24;

  logic        clk;
  logic        rst;
  logic        rd       [N_INST];
  logic        wr       [N_INST];
  logic [31:0] addr_s   [N_INST];
  logic [31:0] wdata_s  [N_INST];
  logic [31:0] rdata_s  [N_INST];
  logic        ready_s  [N_INST];
  logic        busy_s   [N_INST];
  logic        mis_s    [N_INST];

  int lat_of [N_INST] = '{2, 3, 4, 1};

  typedef struct {
    int          lat;
    logic        mis;
    logic        is_write;
    logic [7:0]  idx;
    logic [31:0] wdata;
    logic [31:0] rdata;
    string       tag;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model_mem   [N_INST][256];
  logic [31:0] model_rdata [N_INST];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    data_mem_responder #(
      .DATA_WIDTH (32),
      .DEPTH_LOG2 (8),
      .LATENCY    ((g == 3) ? 1 : g + 2)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .mem_read   (rd[g]),
      .mem_write  (wr[g]),
      .addr       (addr_s[g]),
      .wdata      (wdata_s[g]),
      .rdata      (rdata_s[g]),
      .ready      (ready_s[g]),
      .busy       (busy_s[g]),
      .misaligned (mis_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_models();
    for (int i = 0; i < N_INST; i++) model_rdata[i] = 32'h0;
  endtask

  task automatic check_idle_outputs(input int i, input string tag);
    compare($sformatf("%s.rdata[%0d]", tag, i), rdata_s[i], 32'h0);
    compare($sformatf("%s.ready[%0d]", tag, i), {31'b0, ready_s[i]}, 32'h0);
    compare($sformatf("%s.busy[%0d]", tag, i), {31'b0, busy_s[i]}, 32'h0);
    compare($sformatf("%s.mis[%0d]", tag, i), {31'b0, mis_s[i]}, 32'h0);
  endtask

  // Drive one request on instance i and push its expected response.
  task automatic apply_stimulus(input int i, input logic r, input logic w,
                                input logic [31:0] a, input logic [31:0] d,
                                input string tag);
    exp_t e;
    e.mis      = (a[1:0] != 2'b00);
    e.lat      = e.mis ? 1 : lat_of[i];
    e.is_write = w && !e.mis;
    e.idx      = a[9:2];
    e.wdata    = d;
    if (!e.mis && !w && r) model_rdata[i] = model_mem[i][e.idx];
    e.rdata    = model_rdata[i];
    e.tag      = tag;
    sb.push_back(e);
    rd[i]      = r;
    wr[i]      = w;
    addr_s[i]  = a;
    wdata_s[i] = d;
  endtask

  // Wait (bounded) for ready on instance i and compare against the queue head.
  task automatic check_output(input int i);
    exp_t e;
    int   cycles;
    bit   seen;
    e      = sb.pop_front();
    cycles = 0;
    seen   = 0;
    while (cycles < BUDGET && !seen) begin
      step();
      cycles++;
      if (ready_s[i]) begin
        seen = 1;
      end else begin
        compare($sformatf("%s.busy_c%0d", e.tag, cycles), {31'b0, busy_s[i]}, 32'h1);
      end
    end
    rd[i] = 1'b0;
    wr[i] = 1'b0;
    if (!seen) begin
      compare($sformatf("%s.timeout", e.tag), 32'(cycles), 32'(e.lat));
    end else begin
      compare($sformatf("%s.latency", e.tag), 32'(cycles), 32'(e.lat));
      compare($sformatf("%s.mis", e.tag), {31'b0, mis_s[i]}, {31'b0, e.mis});
      compare($sformatf("%s.busy_at_ready", e.tag), {31'b0, busy_s[i]}, 32'h0);
      compare($sformatf("%s.rdata", e.tag), rdata_s[i], e.rdata);
      if (e.is_write) model_mem[i][e.idx] = e.wdata;
      step();
      compare($sformatf("%s.ready_drop", e.tag), {31'b0, ready_s[i]}, 32'h0);
      compare($sformatf("%s.mis_drop", e.tag), {31'b0, mis_s[i]}, 32'h0);
    end
  endtask

  task automatic access(input int i, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    apply_stimulus(i, r, w, a, d, tag);
    check_output(i);
  endtask

  // Store 0x11111111 to 0x30 on instance 1 (LATENCY 3) and reset it either
  // in WAIT or in the RESP cycle; the old word must survive.
  task automatic reset_mid_write(input bit at_resp, input string tag);
    int  cycles;
    bit  seen;
    rd[1] = 1'b0; wr[1] = 1'b1; addr_s[1] = 32'h30; wdata_s[1] = 32'h11111111;
    step();
    compare($sformatf("%s.busy_n1", tag), {31'b0, busy_s[1]}, 32'h1);
    if (at_resp) begin
      cycles = 1;
      seen   = 0;
      while (cycles < BUDGET && !seen) begin
        step();
        cycles++;
        seen = ready_s[1];
      end
      compare($sformatf("%s.resp_latency", tag), 32'(cycles), 32'd3);
    end
    rst   = 1'b1;
    wr[1] = 1'b0;
    step();
    rst = 1'b0;
    reset_models();
    check_idle_outputs(1, tag);
    for (int k = 0; k < 5; k++) begin
      step();
      compare($sformatf("%s.no_ready_c%0d", tag, k), {31'b0, ready_s[1]}, 32'h0);
    end
    access(1, 1'b1, 1'b0, 32'h30, 32'h0, {tag, ".lw30"});
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N_INST; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr_s[i] = 32'h0; wdata_s[i] = 32'h0;
    end
    reset_models();

    $display("[TB] reset");
    for (int c = 0; c < 2; c++) begin
      step();
      for (int i = 0; i < N_INST; i++) check_idle_outputs(i, $sformatf("rst_c%0d", c));
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      for (int i = 0; i < N_INST; i++) check_idle_outputs(i, $sformatf("idle_c%0d", c));
    end

    $display("[TB] write then read, LATENCY 2");
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "sw10");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, "lw10");

    $display("[TB] misaligned, LATENCY 4 and 2");
    access(2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "l4.sw10");
    access(2, 1'b0, 1'b1, 32'h13, 32'h12345678, "l4.sw13");
    access(2, 1'b1, 1'b0, 32'h10, 32'h0, "l4.lw10");
    access(0, 1'b1, 1'b0, 32'h12, 32'h0, "lw12_mis");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, "lw10_again");

    $display("[TB] simultaneous read and write");
    access(0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, "rw20");
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, "lw20");

    $display("[TB] address wrap");
    access(0, 1'b0, 1'b1, 32'h400, 32'h0000CAFE, "sw400");
    access(0, 1'b1, 1'b0, 32'h000, 32'h0, "lw000");
    access(0, 1'b1, 1'b0, 32'h3FC, 32'h0, "lw3fc_pre");

    $display("[TB] LATENCY 1");
    access(3, 1'b0, 1'b1, 32'h44, 32'h0BADF00D, "l1.sw44");
    access(3, 1'b1, 1'b0, 32'h44, 32'h0, "l1.lw44");
    access(3, 1'b1, 1'b0, 32'h45, 32'h0, "l1.lw45_mis");

    $display("[TB] random word traffic, LATENCY 2");
    for (int k = 0; k < 8; k++)
      access(0, 1'b0, 1'b1, 32'h100 + 32'(4 * k), $urandom, $sformatf("rnd_sw%0d", k));
    for (int k = 7; k >= 0; k--)
      access(0, 1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'h0, $sformatf("rnd_lw%0d", k));

    $display("[TB] reset mid-access, LATENCY 3");
    access(1, 1'b0, 1'b1, 32'h30, 32'h22222222, "l3.sw30_old");
    reset_mid_write(1'b0, "rst_wait");
    reset_mid_write(1'b1, "rst_resp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
